// File: rtl/msg_asm_pkg.sv
// rtl/msg_asm_pkg.sv - shared state type and sizing helpers for the message assembler
package msg_asm_pkg;

    typedef enum logic {COLLECT, PENDING} msg_asm_state_t;

    function automatic int beats(input int msg_bits, input int byte_w);
        return msg_bits / byte_w;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/msg_assembler.sv
// rtl/msg_assembler.sv - packs BYTE_W beats into MSG_BITS messages with early-last and valid/ready output
// Optional idle-timeout partial flush enabled by defining MSG_ASM_TIMEOUT_EN.
module msg_assembler
    import msg_asm_pkg::*;
#(
    parameter int BYTE_W      = 8,
    parameter int MSG_BITS    = 32,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 16,
    localparam int BEATS      = beats(MSG_BITS, BYTE_W),
    localparam int CNT_W      = cnt_w(BEATS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BYTE_W-1:0]   byte_i,
    input  logic                byte_valid_i,
    input  logic                byte_last_i,
    output logic                byte_ready_o,
    output logic [MSG_BITS-1:0] msg_o,
    output logic [CNT_W-1:0]    msg_nbytes_o,
    output logic                msg_partial_o,
    output logic                msg_valid_o,
    input  logic                msg_ready_i
);

    if (MSG_BITS % BYTE_W != 0) begin : g_bad_width
        $error("MSG_BITS must be an integer multiple of BYTE_W");
    end

    msg_asm_state_t      state, state_next;
    logic [MSG_BITS-1:0] asm_reg, asm_next;
    logic [CNT_W-1:0]    cnt, count_next;
    logic                accept, flush, complete, out_free, load_out;

    // Ready depends on FSM state only, so upstream never sees a combinational loop.
    assign byte_ready_o = (state == COLLECT);
    assign accept       = byte_valid_i & byte_ready_o;
    assign out_free     = !msg_valid_o | msg_ready_i;
    assign count_next   = cnt + CNT_W'(accept);

    for (genvar i = 0; i < BEATS; i++) begin : g_lane
        localparam int LO = (MSB_FIRST != 0) ? MSG_BITS - (i + 1) * BYTE_W : i * BYTE_W;
        assign asm_next[LO +: BYTE_W] = (accept && cnt == CNT_W'(i)) ? byte_i : asm_reg[LO +: BYTE_W];
    end

`ifdef MSG_ASM_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle;

    assign idle  = (state == COLLECT) && (cnt != '0) && !accept;
    assign flush = idle && (idle_cnt == IDLE_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (!idle || flush) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign flush = 1'b0;
`endif

    assign complete = (accept && (byte_last_i || cnt == CNT_W'(BEATS - 1))) || flush;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    if (out_free) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = PENDING;
                    end
                end
            end
            PENDING: begin
                if (out_free) begin
                    load_out   = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // In PENDING asm_reg/cnt already hold the finished message, so asm_next/count_next pass them through.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            asm_reg       <= '0;
            cnt           <= '0;
            msg_o         <= '0;
            msg_nbytes_o  <= '0;
            msg_partial_o <= 1'b0;
            msg_valid_o   <= 1'b0;
        end else if (load_out) begin
            msg_o         <= asm_next;
            msg_nbytes_o  <= count_next;
            msg_partial_o <= (count_next < CNT_W'(BEATS));
            msg_valid_o   <= 1'b1;
            asm_reg       <= '0;
            cnt           <= '0;
        end else begin
            if (msg_ready_i) begin
                msg_valid_o <= 1'b0;
            end
            if (accept) begin
                asm_reg <= asm_next;
                cnt     <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_msg_assembler.sv
// tb/tb_msg_assembler.sv - directed plus randomized bench for msg_assembler against a byte-queue reference model
module tb_msg_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_d;
    logic        byte_valid, byte_last, msg_ready;
    logic        byte_ready, partial, valid;
    logic [31:0] msg;
    logic [2:0]  nbytes;
    logic        byte_ready_l, partial_l, valid_l;
    logic [31:0] msg_l;
    logic [2:0]  nbytes_l;

    msg_assembler #(.BYTE_W(8), .MSG_BITS(32), .MSB_FIRST(1), .TIMEOUT_CYC(4)) u_msb (
        .clk_i(clk), .rst_i(rst), .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_last_i(byte_last),
        .byte_ready_o(byte_ready), .msg_o(msg), .msg_nbytes_o(nbytes), .msg_partial_o(partial),
        .msg_valid_o(valid), .msg_ready_i(msg_ready)
    );

    msg_assembler #(.BYTE_W(8), .MSG_BITS(32), .MSB_FIRST(0), .TIMEOUT_CYC(4)) u_lsb (
        .clk_i(clk), .rst_i(rst), .byte_i(byte_d), .byte_valid_i(byte_valid), .byte_last_i(byte_last),
        .byte_ready_o(byte_ready_l), .msg_o(msg_l), .msg_nbytes_o(nbytes_l), .msg_partial_o(partial_l),
        .msg_valid_o(valid_l), .msg_ready_i(msg_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int seen   = 0;
    logic [7:0]  cur[$];
    logic [31:0] exp_msb_q[$];
    logic [31:0] exp_lsb_q[$];
    int          exp_n_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // A message is whatever beats were gathered, placed by position; unused bytes stay zero.
    task automatic model_complete();
        logic [31:0] m = '0;
        logic [31:0] l = '0;
        for (int k = 0; k < cur.size(); k++) begin
            m = m | ({24'b0, cur[k]} << (8 * (3 - k)));
            l = l | ({24'b0, cur[k]} << (8 * k));
        end
        exp_msb_q.push_back(m);
        exp_lsb_q.push_back(l);
        exp_n_q.push_back(cur.size());
        cur.delete();
    endtask

    task automatic model_reset();
        cur.delete();
        exp_msb_q.delete();
        exp_lsb_q.delete();
        exp_n_q.delete();
    endtask

    task automatic tick();
        if (valid && msg_ready) begin
            seen++;
            if (exp_msb_q.size() == 0) begin
                check("unexpected_msg", valid, 0);
            end else begin
                int n;
                n = exp_n_q.pop_front();
                check("sb_msg_msb", msg, exp_msb_q.pop_front());
                check("sb_msg_lsb", msg_l, exp_lsb_q.pop_front());
                check("sb_nbytes", nbytes, n);
                check("sb_nbytes_lsb", nbytes_l, n);
                check("sb_partial", partial, n < 4);
            end
        end
        if (byte_valid && byte_ready) begin
            cur.push_back(byte_d);
            if (byte_last || cur.size() == 4) model_complete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] b, input logic last);
        byte_valid = 1'b1;
        byte_d     = b;
        byte_last  = last;
        tick();
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_burst(input int n, output int sent);
        sent = 0;
        for (int c = 0; c < 3 * n && sent < n; c++) begin
            logic acc;
            byte_valid = 1'b1;
            byte_d     = 8'(sent + 1);
            byte_last  = 1'b0;
            acc        = byte_ready;
            tick();
            if (acc) sent++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msg"}, msg, 0);
        check({tag, "_nbytes"}, nbytes, 0);
        check({tag, "_partial"}, partial, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_ready"}, byte_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int seen0;
        rst        = 1'b1;
        byte_d     = '0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        msg_ready  = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // full message, MSB first
        msg_ready = 1'b1;
        drive(8'h11, 0);
        drive(8'h22, 0);
        drive(8'h33, 0);
        check("full_not_yet_valid", valid, 0);
        drive(8'h44, 0);
        check("full_valid", valid, 1);
        check("full_msg", msg, 32'h11223344);
        check("full_nbytes", nbytes, 4);
        check("full_partial", partial, 0);
        tick();

        // early last
        drive(8'hAA, 0);
        drive(8'hBB, 1);
        check("early_msg_msb", msg, 32'hAABB0000);
        check("early_msg_lsb", msg_l, 32'h0000BBAA);
        check("early_nbytes", nbytes, 2);
        check("early_partial", partial, 1);
        tick();

        // backpressure: second message parks in PENDING
        msg_ready = 1'b0;
        send_burst(8, sent);
        check("bp_beats_sent", sent, 8);
        check("bp_msg_held", msg, 32'h01020304);
        check("bp_ready_low", byte_ready, 0);
        tick();
        tick();
        check("bp_msg_stable", msg, 32'h01020304);
        check("bp_valid_held", valid, 1);
        msg_ready = 1'b1;
        tick();
        check("bp_second_msg", msg, 32'h05060708);
        check("bp_second_valid", valid, 1);
        check("bp_ready_back", byte_ready, 1);
        tick();
        check("bp_valid_drop", valid, 0);

        // streaming
        seen0 = seen;
        for (int i = 0; i < 12; i++) begin
            check("stream_ready", byte_ready, 1);
            drive(8'($urandom), 0);
            byte_valid = 1'b1;
        end
        byte_valid = 1'b0;
        tick();
        tick();
        check("stream_msg_count", seen - seen0, 3);

        // reset mid-message
        drive(8'h77, 0);
        drive(8'h88, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        seen0 = seen;
        repeat (8) tick();
        check("rst_mid_no_msg", seen - seen0, 0);

        // reset during PENDING
        msg_ready = 1'b0;
        send_burst(8, sent);
        check("rst_pend_valid_before", valid, 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_pend");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        msg_ready = 1'b1;
        seen0 = seen;
        repeat (8) tick();
        check("rst_pend_no_msg", seen - seen0, 0);

`ifdef MSG_ASM_TIMEOUT_EN
        drive(8'h5A, 0);
        model_complete();
        for (int k = 0; k < 20 && !valid; k++) tick();
        check("timeout_valid", valid, 1);
        check("timeout_msg", msg, 32'h5A000000);
        check("timeout_nbytes", nbytes, 1);
        check("timeout_partial", partial, 1);
        tick();
`else
        drive(8'h5A, 0);
        repeat (20) tick();
        check("no_timeout_valid", valid, 0);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
`endif

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
`ifdef MSG_ASM_TIMEOUT_EN
            byte_valid = 1'b1;
`else
            byte_valid = ($urandom_range(0, 3) != 0);
`endif
            byte_d    = 8'($urandom);
            byte_last = ($urandom_range(0, 5) == 0);
            msg_ready = ($urandom_range(0, 2) != 0);
            check("rand_ready_match", byte_ready_l, byte_ready);
            tick();
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        msg_ready  = 1'b1;
`ifdef MSG_ASM_TIMEOUT_EN
        repeat (12) tick();
`else
        repeat (6) tick();
        if (cur.size() != 0) begin
            byte_valid = 1'b1;
            byte_last  = 1'b1;
            byte_d     = 8'hC3;
            tick();
            byte_valid = 1'b0;
            byte_last  = 1'b0;
            repeat (4) tick();
        end
`endif
        check("rand_drained", exp_msb_q.size(), 0);
        check("rand_final_valid", valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
